nibble_serial_adder: RTL and testbench

- Multi-cycle wide adder that drives one 4-bit carry-lookahead slice per cycle.
- Operands of WIDTH bits are captured on a start request and consumed least-significant nibble first.
- The slice carry-out is registered and fed back as the next slice carry-in.
- Sits directly upstream of the 4-bit CLA slice: it sequences operand nibbles into the slice and assembles its sum/carry outputs into a wide result with a start/busy/done handshake.

---
 rtl/nibble_serial_adder.sv | 199 +++++++++++++++++++
 tb/tb_nibble_serial_adder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: adds two WIDTH-bit operands one nibble per clock.
// A single 4-bit carry-lookahead slice is reused every cycle. The slice
// carry-out is registered and fed back as the next nibble's carry-in, so
// the critical path stays one CLA slice regardless of WIDTH.

module nibble_cla4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c3_o,
  output logic       c4_o
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  // Generate/propagate lookahead: every carry is a flat sum of products of c_i.
  always_comb begin
    p    = a_i ^ b_i;
    g    = a_i & b_i;
    c[0] = c_i;
    c[1] = g[0] | (p[0] & c_i);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c_i);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c_i);
    s_o  = p ^ c[3:0];
    c3_o = c[3];
    c4_o = c[4];
  end

endmodule

// State table
//   state  | meaning
//   S_IDLE | waiting for start; result registers hold last answer
//   S_RUN  | one nibble added per cycle, LSB nibble first
//   S_DONE | single-cycle done pulse, result valid
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N    = WIDTH / 4;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [3:0] slice_a;
  logic [3:0] slice_b;
  logic [3:0] slice_s;
  logic       slice_c3;
  logic       slice_c4;

  // Pick the current operand nibbles out of the captured operands.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_q == IDXW'(i)) begin
        slice_a = a_q[4*i +: 4];
        slice_b = b_q[4*i +: 4];
      end
    end
  end

  nibble_cla4 u_slice (
    .a_i  (slice_a),
    .b_i  (slice_b),
    .c_i  (carry_q),
    .s_o  (slice_s),
    .c3_o (slice_c3),
    .c4_o (slice_c4)
  );

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start only matters in IDLE; DONE always returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN:  if (idx_q == LAST_IDX) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode straight from the state register.
  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
  end

  // Datapath next-state: capture on accepted start, accumulate one nibble per RUN cycle.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          idx_d   = '0;
        end
      end
      S_RUN: begin
        for (int i = 0; i < N; i++) begin
          if (idx_q == IDXW'(i)) begin
            sum_d[4*i +: 4] = slice_s;
          end
        end
        carry_d = slice_c4;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d = slice_c4;
          // Signed overflow: carry into the MSB differs from carry out of it.
          ovf_d  = slice_c3 ^ slice_c4;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset clears everything and aborts any operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: directed and random additions on a 16-bit
// and a 4-bit instance, checked against plain integer arithmetic.
module tb_nibble_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start;
  logic [15:0] a, b;
  logic        cin;
  logic        busy, done;
  logic [15:0] sum;
  logic        cout, ovf;

  logic        start4;
  logic [3:0]  a4, b4;
  logic        cin4;
  logic        busy4, done4;
  logic [3:0]  sum4;
  logic        cout4, ovf4;

  int compared   = 0;
  int mismatched = 0;

  nibble_serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: returns {ovf, cout, sum[15:0]} for a w-bit addition.
  function automatic logic [17:0] ref_add(input int w, input logic [15:0] x,
                                          input logic [15:0] y, input logic c);
    int u, sx, sy, s, full;
    logic [17:0] r;
    full = 1 << w;
    u    = int'(x) + int'(y) + int'(c);
    sx   = x[w-1] ? int'(x) - full : int'(x);
    sy   = y[w-1] ? int'(y) - full : int'(y);
    s    = sx + sy + int'(c);
    r        = '0;
    r[15:0]  = 16'(u % full);
    r[16]    = ((u / full) % 2) == 1;
    r[17]    = (s > (full / 2) - 1) || (s < -(full / 2));
    return r;
  endfunction

  task automatic run16(input logic [15:0] x, input logic [15:0] y, input logic c,
                       input bit disturb);
    logic [17:0] e;
    int cyc, busy_cnt, done_cnt;
    e = ref_add(16, x, y, c);
    a = x; b = y; cin = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; busy_cnt = 0;
    while (done !== 1'b1 && cyc < 20) begin
      if (busy === 1'b1) busy_cnt++;
      chk("partial_sum", {16'h0, sum}, {16'h0, e[15:0] & 16'((32'h1 << (4 * cyc)) - 1)});
      if (disturb && cyc == 0) begin
        start = 1'b1; a = 16'h1234; b = ~y; cin = ~c;
      end else if (disturb && cyc == 1) begin
        start = 1'b0; a = 16'h5a5a;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency16", cyc, 4);
    chk("busy_cycles16", busy_cnt, 4);
    chk("busy_at_done16", {31'h0, busy}, 0);
    chk("sum16", {16'h0, sum}, {16'h0, e[15:0]});
    chk("cout16", {31'h0, cout}, {31'h0, e[16]});
    chk("ovf16", {31'h0, ovf}, {31'h0, e[17]});
    done_cnt = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_cnt++;
    end
    chk("extra_done16", done_cnt, 0);
    chk("idle_after16", {31'h0, busy}, 0);
    chk("sum_hold16", {16'h0, sum}, {16'h0, e[15:0]});
  endtask

  task automatic run4(input logic [3:0] x, input logic [3:0] y, input logic c);
    logic [17:0] e;
    int cyc;
    e = ref_add(4, {12'h0, x}, {12'h0, y}, c);
    a4 = x; b4 = y; cin4 = c; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    chk("busy4_run", {31'h0, busy4}, 1);
    cyc = 0;
    while (done4 !== 1'b1 && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency4", cyc, 1);
    chk("sum4", {28'h0, sum4}, {28'h0, e[3:0]});
    chk("cout4", {31'h0, cout4}, {31'h0, e[16]});
    chk("ovf4", {31'h0, ovf4}, {31'h0, e[17]});
    @(posedge clk); #1;
  endtask

  initial begin
    int last_done, n_done;
    logic [17:0] e4;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_done", {31'h0, done}, 0);
    chk("rst_sum", {16'h0, sum}, 0);
    chk("rst_cout_ovf", {30'h0, cout, ovf}, 0);
    chk("rst4_all", {24'h0, busy4, done4, cout4, ovf4, sum4}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run16(16'h0001, 16'h0000, 1'b0, 1'b0);
    run16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    run16(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    run16(16'h8000, 16'h8000, 1'b0, 1'b0);
    run16(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);

    // Reset on the second RUN cycle aborts the operation.
    a = 16'h00F0; b = 16'h0010; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_state", {29'h0, busy, done, cout}, 0);
    chk("abort_sum_ovf", {15'h0, ovf, sum}, 0);
    n_done = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) n_done++;
    end
    chk("abort_no_done", n_done, 0);
    run16(16'h1234, 16'h4321, 1'b1, 1'b0);

    for (int i = 0; i < 30; i++) begin
      run16(16'($urandom), 16'($urandom), 1'($urandom), (i % 5) == 0);
    end

    run4(4'hF, 4'h1, 1'b1);
    run4(4'h7, 4'h1, 1'b0);
    run4(4'h8, 4'h8, 1'b0);
    for (int i = 0; i < 15; i++) begin
      run4(4'($urandom), 4'($urandom), 1'($urandom));
    end

    // Start held high: one acceptance every three cycles.
    a4 = 4'h9; b4 = 4'h9; cin4 = 1'b1;
    e4 = ref_add(4, 16'h9, 16'h9, 1'b1);
    start4 = 1'b1;
    n_done = 0; last_done = -1;
    for (int s = 1; s <= 12; s++) begin
      @(posedge clk); #1;
      if (done4 === 1'b1) begin
        n_done++;
        if (last_done >= 0) chk("b2b_period", s - last_done, 3);
        else chk("b2b_first", s, 2);
        chk("b2b_sum", {27'h0, ovf4, cout4, sum4}, {27'h0, e4[17], e4[16], e4[3:0]});
        last_done = s;
      end
    end
    start4 = 1'b0;
    chk("b2b_count", n_done, 4);
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
